// File: rtl/fetch_pkg.sv
// Shared widths, state encoding and PC helper for the instruction fetch stage.
package fetch_pkg;

  localparam int CPU_ADDR_WIDTH  = 32;
  localparam int CPU_INSTR_WIDTH = 32;

  localparam logic [CPU_INSTR_WIDTH-1:0] INSTR_NOP = '0;
  localparam logic [CPU_ADDR_WIDTH-1:0]  PC_STEP   = CPU_ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  // Sequential successor; wraps naturally at the top of the address space.
  function automatic logic [CPU_ADDR_WIDTH-1:0] next_seq_pc(input logic [CPU_ADDR_WIDTH-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding bus read, zero-latency bypass of the
// response word, a single-entry hold buffer for downstream stalls, and redirect handling.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [CPU_ADDR_WIDTH-1:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_exec_stall,
  input  logic                       i_mem_stall,
  input  logic                       i_jump_valid,
  input  logic [CPU_ADDR_WIDTH-1:0]  i_jump_addr,
  output logic [CPU_ADDR_WIDTH-1:0]  o_ibus_addr,
  output logic                       o_ibus_rd,
  input  logic                       i_ibus_accept,
  input  logic                       i_ibus_rdy,
  input  logic [CPU_INSTR_WIDTH-1:0] i_ibus_data,
  input  logic                       i_ibus_err,
  output logic [CPU_INSTR_WIDTH-1:0] o_instr,
  output logic [CPU_ADDR_WIDTH-1:0]  o_pc,
  output logic                       o_fetch_stall,
  output logic                       o_ibus_fault
);

  fetch_state_e               r_state;
  logic [CPU_ADDR_WIDTH-1:0]  r_fetch_pc;
  logic                       r_discard;
  logic [CPU_INSTR_WIDTH-1:0] r_hold_data;
  logic                       r_hold_err;
  logic [CPU_ADDR_WIDTH-1:0]  r_hold_pc;

  logic                       w_resp_live;
  logic                       w_word_valid;
  logic                       w_down_stall;
  logic                       w_consume;
  logic [CPU_INSTR_WIDTH-1:0] w_word;
  logic                       w_word_err;

  // A response flagged for discard never counts as a deliverable word.
  assign w_resp_live  = (r_state == ST_WAIT) && i_ibus_rdy && !r_discard;
  assign w_word_valid = w_resp_live || (r_state == ST_HOLD);
  assign w_down_stall = i_exec_stall || i_mem_stall;
  assign w_consume    = w_word_valid && !w_down_stall && !i_jump_valid;

  assign w_word     = (r_state == ST_HOLD) ? r_hold_data : i_ibus_data;
  assign w_word_err = (r_state == ST_HOLD) ? r_hold_err  : i_ibus_err;

  assign o_ibus_rd     = (r_state == ST_ISSUE);
  assign o_ibus_addr   = r_fetch_pc;
  assign o_fetch_stall = !w_word_valid || i_jump_valid;
  assign o_instr       = (o_fetch_stall || w_word_err) ? INSTR_NOP : w_word;
  assign o_ibus_fault  = !o_fetch_stall && w_word_err;
  assign o_pc          = (r_state == ST_HOLD) ? r_hold_pc : r_fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ISSUE;
      r_fetch_pc  <= RESET_PC;
      r_discard   <= 1'b0;
      r_hold_data <= '0;
      r_hold_err  <= 1'b0;
      r_hold_pc   <= '0;
    end else begin
      case (r_state)
        ST_ISSUE: begin
          if (i_jump_valid) r_fetch_pc <= i_jump_addr;
          // A read accepted alongside a redirect fetches the old address, so drop it.
          if (i_ibus_accept) begin
            r_state   <= ST_WAIT;
            r_discard <= i_jump_valid;
          end
        end
        ST_WAIT: begin
          if (i_jump_valid) r_fetch_pc <= i_jump_addr;
          if (i_ibus_rdy) begin
            r_discard <= 1'b0;
            if (w_consume) begin
              r_fetch_pc <= next_seq_pc(r_fetch_pc);
              r_state    <= ST_ISSUE;
            end else if (r_discard || i_jump_valid) begin
              r_state <= ST_ISSUE;
            end else begin
              r_state     <= ST_HOLD;
              r_hold_data <= i_ibus_data;
              r_hold_err  <= i_ibus_err;
              r_hold_pc   <= r_fetch_pc;
            end
          end else if (i_jump_valid) begin
            r_discard <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (i_jump_valid) begin
            r_fetch_pc  <= i_jump_addr;
            r_state     <= ST_ISSUE;
            r_hold_data <= '0;
            r_hold_err  <= 1'b0;
          end else if (!w_down_stall) begin
            r_fetch_pc <= next_seq_pc(r_fetch_pc);
            r_state    <= ST_ISSUE;
          end
        end
        default: r_state <= ST_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios, then randomized bus/stall/redirect
// traffic checked by a scoreboard fed from an instruction-stream reference model.
module tb_fetch;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_exec_stall, i_mem_stall, i_jump_valid;
   logic [31:0] i_jump_addr;
   logic [31:0] o_ibus_addr;
   logic        o_ibus_rd;
   logic        i_ibus_accept, i_ibus_rdy, i_ibus_err;
   logic [31:0] i_ibus_data;
   logic [31:0] o_instr, o_pc;
   logic        o_fetch_stall, o_ibus_fault;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   int   checks   = 0;
   int   failures = 0;
   int   consumes = 0;
   bit   sbOn     = 1'b0;

   always #5 clk = ~clk;

   fetch #(.RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_exec_stall (i_exec_stall),
      .i_mem_stall  (i_mem_stall),
      .i_jump_valid (i_jump_valid),
      .i_jump_addr  (i_jump_addr),
      .o_ibus_addr  (o_ibus_addr),
      .o_ibus_rd    (o_ibus_rd),
      .i_ibus_accept(i_ibus_accept),
      .i_ibus_rdy   (i_ibus_rdy),
      .i_ibus_data  (i_ibus_data),
      .i_ibus_err   (i_ibus_err),
      .o_instr      (o_instr),
      .o_pc         (o_pc),
      .o_fetch_stall(o_fetch_stall),
      .o_ibus_fault (o_ibus_fault)
   );

   // Memory image seen by the bus model; a few addresses answer with a bus error.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic memErr(input logic [31:0] a);
      return a[6:2] == 5'd7;
   endfunction

   function automatic exp_t expectAt(input logic [31:0] a);
      exp_t e;
      e.pc    = a;
      e.fault = memErr(a);
      e.instr = e.fault ? 32'h0 : memWord(a);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic ex, input logic ms, input logic jv,
                                input logic [31:0] ja, input logic acc, input logic rdy,
                                input logic [31:0] d, input logic er);
      @(posedge clk);
      #1;
      rst = r; i_exec_stall = ex; i_mem_stall = ms; i_jump_valid = jv; i_jump_addr = ja;
      i_ibus_accept = acc; i_ibus_rdy = rdy; i_ibus_data = d; i_ibus_err = er;
      #1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_rd"},    32'(o_ibus_rd),     32'd1);
      checkOutput({tag, "_addr"},  o_ibus_addr,        RST_PC);
      checkOutput({tag, "_stall"}, 32'(o_fetch_stall), 32'd1);
      checkOutput({tag, "_instr"}, o_instr,            32'h0);
      checkOutput({tag, "_pc"},    o_pc,               RST_PC);
      checkOutput({tag, "_fault"}, 32'(o_ibus_fault),  32'd0);
   endtask

   // Scoreboard monitor: every delivered-and-consumed word must match the model's next entry.
   always @(negedge clk) begin
      if (sbOn) begin
         if (o_fetch_stall) begin
            checkOutput("stall_nop", o_instr, 32'h0);
         end else if (!i_exec_stall && !i_mem_stall) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_delivery: got pc %h, expected no word", o_pc);
            end else begin
               monE = expQ.pop_front();
               consumes++;
               checkOutput("deliver_pc",    o_pc,              monE.pc);
               checkOutput("deliver_instr", o_instr,           monE.instr);
               checkOutput("deliver_fault", 32'(o_ibus_fault), 32'(monE.fault));
            end
         end
      end
   end

   logic [31:0] nextPc, pAddr, sAddr, tgt;
   logic        pending, dAccept, dRdy, sRd, jv;
   int          cnt;

   initial begin
      rst = 1'b1; i_exec_stall = 0; i_mem_stall = 0; i_jump_valid = 0; i_jump_addr = 0;
      i_ibus_accept = 0; i_ibus_rdy = 0; i_ibus_data = 0; i_ibus_err = 0;

      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkResetOutputs("reset");

      // First fetch after reset, response one cycle after accept.
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("first_addr", o_ibus_addr, 32'hBFC0_0000);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h2408_0001, 0);
      checkOutput("first_stall", 32'(o_fetch_stall), 32'd0);
      checkOutput("first_instr", o_instr, 32'h2408_0001);
      checkOutput("first_pc", o_pc, 32'hBFC0_0000);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("seq_addr", o_ibus_addr, 32'hBFC0_0004);

      // Redirect near the top of memory, then sequential wrap to zero.
      applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      checkOutput("redir_addr_same_cycle", o_ibus_addr, 32'hBFC0_0004);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("redir_addr", o_ibus_addr, 32'hFFFF_FFFC);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h1111_2222, 0);
      checkOutput("top_instr", o_instr, 32'h1111_2222);
      applyStimulus(0, 0, 0, 1, 32'h0000_0100, 0, 0, 0, 0);
      checkOutput("wrap_addr", o_ibus_addr, 32'h0000_0000);

      // Errored response.
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
      checkOutput("err_instr", o_instr, 32'h0);
      checkOutput("err_fault", 32'(o_ibus_fault), 32'd1);
      checkOutput("err_pc", o_pc, 32'h0000_0100);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("err_next_addr", o_ibus_addr, 32'h0000_0104);

      // Redirect while waiting: the late response is swallowed.
      applyStimulus(0, 0, 0, 1, 32'h8000_0180, 0, 0, 0, 0);
      checkOutput("wait_redir_stall", 32'(o_fetch_stall), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 0);
      checkOutput("late_resp_stall", 32'(o_fetch_stall), 32'd1);
      checkOutput("late_resp_instr", o_instr, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("late_redir_addr", o_ibus_addr, 32'h8000_0180);

      // Downstream stall holds the word without issuing another read.
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 32'h0A0A_0A0A, 0);
      checkOutput("hold_enter_instr", o_instr, 32'h0A0A_0A0A);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'h0, 0);
         checkOutput("hold_instr", o_instr, 32'h0A0A_0A0A);
         checkOutput("hold_no_rd", 32'(o_ibus_rd), 32'd0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("hold_release_pc", o_pc, 32'h8000_0180);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("hold_next_addr", o_ibus_addr, 32'h8000_0184);

      // Reset in WAIT, then a stale response must be ignored.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h5555_5555, 0);
      checkResetOutputs("midreset");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("stale_rdy_rd", 32'(o_ibus_rd), 32'd1);
      checkOutput("stale_rdy_addr", o_ibus_addr, RST_PC);

      // Randomized phase.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      expQ.delete();
      expQ.push_back(expectAt(RST_PC));
      nextPc = RST_PC + 32'd4;
      pending = 0; dAccept = 0; dRdy = 0; sRd = 0; sAddr = 0; pAddr = 0; cnt = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk);
         if (dRdy) pending = 0;
         if (sRd && dAccept) begin
            checkOutput("one_outstanding", 32'(pending), 32'd0);
            pending = 1; pAddr = sAddr; cnt = $urandom_range(0, 2);
         end else if (pending && cnt > 0) begin
            cnt--;
         end
         #1;
         sbOn = 1'b1;
         rst = 0;
         i_exec_stall = ($urandom_range(0, 3) == 0);
         i_mem_stall  = ($urandom_range(0, 7) == 0);
         jv = ($urandom_range(0, 11) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4)
                                           : ($urandom & 32'hFFFF_FFFC);
         i_jump_valid = jv;
         i_jump_addr  = tgt;
         i_ibus_accept = ($urandom_range(0, 3) != 0);
         if (pending && cnt == 0) begin
            i_ibus_rdy = 1; i_ibus_data = memWord(pAddr); i_ibus_err = memErr(pAddr);
         end else begin
            i_ibus_rdy  = !pending && ($urandom_range(0, 15) == 0);
            i_ibus_data = $urandom;
            i_ibus_err  = ($urandom_range(0, 1) == 0);
         end
         dAccept = i_ibus_accept;
         dRdy    = i_ibus_rdy;
         if (jv) begin
            expQ.delete();
            expQ.push_back(expectAt(tgt));
            nextPc = tgt + 32'd4;
         end else if (expQ.size() == 0) begin
            expQ.push_back(expectAt(nextPc));
            nextPc = nextPc + 32'd4;
         end
         #7;
         sRd   = o_ibus_rd;
         sAddr = o_ibus_addr;
         if (sRd && i_ibus_accept && !i_jump_valid && expQ.size() != 0)
            checkOutput("issue_addr", sAddr, expQ[0].pc);
      end
      sbOn = 1'b0;
      checkOutput("progress", 32'(consumes > 50), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC0_0000, meaning the first fetch address after reset.
REQ-002 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous reset, active-high.
REQ-003 SHALL have ports: i_exec_stall  in  1  and  i_mem_stall  in  1, meaning downstream stage stalls.
REQ-004 SHALL have port i_jump_valid  in  1, meaning the redirect request strobe (branch, jump or exception).
REQ-005 SHALL have port i_jump_addr  in  32, meaning the redirect target address.
REQ-006 SHALL have port o_ibus_addr  out  32, meaning the instruction bus word address.
REQ-007 SHALL have port o_ibus_rd  out  1, meaning the read command is valid.
REQ-008 SHALL have ports: i_ibus_accept  in  1  command accepted; i_ibus_rdy  in  1  response valid.
REQ-009 SHALL have ports: i_ibus_data  in  32  response word; i_ibus_err  in  1  response error, qualified by i_ibus_rdy.
REQ-010 SHALL have ports: o_instr  out  32  instruction to decode; o_pc  out  32  its address.
REQ-011 SHALL have ports: o_fetch_stall  out  1  o_instr not valid; o_ibus_fault  out  1  o_instr came from an errored response.

Function
REQ-012 SHALL implement a three-state machine: ISSUE (o_ibus_rd=1, o_ibus_addr=fetch_pc), WAIT (response pending) and HOLD (word buffered, downstream stalled).
REQ-013 SHALL move ISSUE->WAIT on i_ibus_accept; o_ibus_addr SHALL stay stable while o_ibus_rd=1 and unaccepted.
REQ-014 SHALL allow at most one outstanding bus read.
REQ-015 SHALL, in WAIT with i_ibus_rdy=1, present i_ibus_data combinationally on o_instr with o_fetch_stall=0 (zero added latency).
REQ-016 SHALL define consume as WAIT/HOLD word valid and !(i_exec_stall || i_mem_stall).
REQ-017 SHALL, on consume, set fetch_pc += 4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0) and enter ISSUE.
REQ-018 SHALL, when a response arrives but is not consumed, latch data/err/pc and enter HOLD; HOLD SHALL exit only on consume.
REQ-019 SHALL drive o_fetch_stall=1 in ISSUE, and in WAIT without i_ibus_rdy; o_instr SHALL be 32'h0000_0000 whenever o_fetch_stall=1.
REQ-020 SHALL, on i_jump_valid, load fetch_pc with i_jump_addr and discard any undelivered word (HOLD contents, or the response in the same cycle); o_fetch_stall=1 in that cycle.
REQ-021 SHALL, on redirect in WAIT before the response, set a discard flag, swallow that response without presenting it, then go to ISSUE at the new fetch_pc.
REQ-022 SHALL, on redirect in ISSUE, switch o_ibus_addr only in the next cycle; if i_ibus_accept coincides with the redirect, that read SHALL be treated as discarded (REQ-021).
REQ-023 SHALL give redirect priority over sequential increment when both occur in one cycle.
REQ-024 SHALL, on an errored response, present o_instr=NOP with o_ibus_fault=1 and o_pc=faulting address, then continue sequentially.
REQ-025 SHALL ignore i_ibus_rdy in ISSUE and i_ibus_accept outside ISSUE.
REQ-026 SHALL hand delay slots to decode naturally: a redirect issued by execute cancels only instructions after the delay slot.

Reset
REQ-027 SHALL, while rst=1 at a clk edge, set state=ISSUE, fetch_pc=RESET_PC, discard=0 and clear the hold buffer.
REQ-028 SHALL drive outputs after reset as: o_ibus_rd=1, o_ibus_addr=RESET_PC, o_fetch_stall=1, o_instr=0, o_pc=RESET_PC, o_ibus_fault=0.
REQ-029 SHALL abandon any outstanding read when reset is asserted mid-transaction; the bus SHALL be reset at the same time.

Structure
REQ-030 SHALL take widths (CPU_ADDR_WIDTH, CPU_INSTR_WIDTH) from the shared CPU include; FSM state encodings SHALL be local parameters in a fetch_const include.
REQ-031 SHALL be a single module with no sub-modules; the hold buffer SHALL be inline registers.

Verification
REQ-032 Reset release, bus accepts immediately, rdy one cycle later with 32'h2408_0001 -> addr 32'hBFC0_0000, o_instr=32'h2408_0001, o_pc=32'hBFC0_0000, next addr 32'hBFC0_0004.
REQ-033 Response arrives with i_exec_stall=1 for 3 cycles -> HOLD, o_instr held stable, no new read, ISSUE 32'hBFC0_0004 after the stall drops.
REQ-034 i_jump_valid with target 32'h8000_0180 while in WAIT -> late response never presented, next read addr 32'h8000_0180.
REQ-035 i_ibus_err with rdy at pc 32'h0000_0100 -> o_instr=0, o_ibus_fault=1, o_pc=32'h0000_0100, next addr 32'h0000_0104.
REQ-036 Redirect to 32'hFFFF_FFFC, then consume -> next addr 32'h0000_0000 (wrap).
REQ-037 Assert rst during WAIT -> all outputs at REQ-028 values next cycle; a stale rdy after reset is ignored in ISSUE.
